cs_bank_delay_ctrl: RTL

//  Parametrised control-store bank/delay controller for the microsequencer, generalising the single-bit
//  LUA12/DMA12 scheme to a BANK_W-bit control-store bank field. It tracks load-control-store (LCS) mode

---
 rtl/cs_bank_delay_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cs_bank_delay_ctrl.sv
// Control-store bank/delay controller: LCS mode tracking, bank/map registers, stretched MDLY.
// Optional delay-cycle statistic counter enabled by defining CS_DLY_STATS_EN.
module cs_bank_delay_ctrl #(
  parameter int BANK_W = 1,
  parameter int DLY_W  = 2
) (
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              CSDELAY0,
  input  logic              CSDLY,
  input  logic [DLY_W-1:0]  CSDLY_LEN,
  input  logic              CSECOND,
  input  logic              CSLOOP,
  input  logic              ACOND_n,
  input  logic [BANK_W-1:0] LUA_BANK,
  input  logic              MAP_n,
  input  logic              LCS_REQ,
  output logic              LCS_n,
  output logic              MDLY_n,
  output logic [BANK_W-1:0] DBANK,
  output logic              DMAP_n,
  output logic              BANKCHG,
  output logic              DLY0_n,
  output logic              SLCOND_n,
  output logic [15:0]       DLY_STATS
);

  typedef enum logic {IDLE, STRETCH} state_t;

  state_t             state, state_nx;
  logic [DLY_W-1:0]   cnt, cnt_nx;
  logic               mdly, mdly_nx;
  logic               lcs;
  logic               dmap;
  logic [BANK_W-1:0]  dbank;
  logic               bankchg;
  logic               acond;
  logic               cond_sel;
  logic               bank_diff;
  logic               wrap;

  assign acond     = ~ACOND_n;
  assign cond_sel  = acond & (CSECOND | CSLOOP);
  assign bank_diff = (LUA_BANK != dbank);
  // Wrap = last bank just left, first bank coming up
  assign wrap      = (dbank == {BANK_W{1'b1}}) &&
                     (LUA_BANK == '0);

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      dbank   <= '0;
      dmap    <= 1'b0;
      bankchg <= 1'b0;
      lcs     <= 1'b1;
    end else begin
      dbank   <= LUA_BANK;
      dmap    <= ~MAP_n;
      bankchg <= bank_diff;
      if (LCS_REQ)
        lcs <= 1'b1;
      else if (wrap)
        lcs <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state <= IDLE;
      cnt   <= '0;
      mdly  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      mdly  <= mdly_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mdly_nx  = mdly;
    unique case (state)
      IDLE: begin
        if (CSDLY) begin
          mdly_nx = 1'b1;
          if (CSDLY_LEN != '0) begin
            cnt_nx   = CSDLY_LEN;
            state_nx = STRETCH;
          end
        end else begin
          mdly_nx = 1'b0;
        end
      end
      STRETCH: begin
        mdly_nx = 1'b1;
        if (CSDLY) begin
          cnt_nx = CSDLY_LEN;
          if (CSDLY_LEN == '0)
            state_nx = IDLE;
        end else begin
          cnt_nx = cnt - DLY_W'(1);
          if (cnt == DLY_W'(1))
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign LCS_n    = ~lcs;
  assign MDLY_n   = ~mdly;
  assign DBANK    = dbank;
  assign DMAP_n   = ~dmap;
  assign BANKCHG  = bankchg;
  assign SLCOND_n = ~cond_sel;
  assign DLY0_n   = ~(mdly | CSDELAY0 | cond_sel |
                      bank_diff | dmap);

`ifdef CS_DLY_STATS_EN
  logic [15:0] stats;

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n)
      stats <= '0;
    else if (LCS_REQ)
      stats <= '0;
    else if (!DLY0_n && stats != 16'hFFFF)
      stats <= stats + 16'd1;
  end

  assign DLY_STATS = stats;
`else
  assign DLY_STATS = 16'h0000;
`endif

endmodule
